// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: register file, immediate and control decode, load-use detection
module decode_stage #(
  parameter logic [31:0] NOP_INSTR  = 32'h00000013,
  parameter logic [31:0] HALT_INSTR = 32'h00000073,
  parameter logic [31:0] RESET_PC   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_dec,
  input  logic [31:0] pc_curr_dec,
  input  logic [31:0] pc_next_dec,
  input  logic        flush,
  input  logic        stall_mem,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        hazard,
  output logic        halt,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [31:0] imm_ex,
  output logic [4:0]  rs1_ex,
  output logic [4:0]  rs2_ex,
  output logic [4:0]  rd_ex,
  output logic [2:0]  funct3_ex,
  output logic        alt_ex,
  output logic [9:0]  ctrl_ex,
  output logic [31:0] pc_curr_ex,
  output logic [31:0] pc_next_ex
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Bubble fields are taken from the canonical NOP so execute sees addi x0,x0,0
  localparam logic [4:0]  NOP_RS1    = NOP_INSTR[19:15];
  localparam logic [4:0]  NOP_RS2    = NOP_INSTR[24:20];
  localparam logic [2:0]  NOP_FUNCT3 = NOP_INSTR[14:12];
  localparam logic [31:0] NOP_IMM    = {{20{NOP_INSTR[31]}}, NOP_INSTR[31:20]};

  logic [31:0] regs [1:31];

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm;
  logic [9:0]  ctrl;
  logic        alt;
  logic        rs1_used, rs2_used;
  logic        is_halt;
  logic        reg_write;

  assign opcode = instruction_dec[6:0];
  assign rd     = instruction_dec[11:7];
  assign funct3 = instruction_dec[14:12];
  assign rs1    = instruction_dec[19:15];
  assign rs2    = instruction_dec[24:20];
  assign is_halt = (instruction_dec == HALT_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Write-through: a same-cycle writeback to the source register wins over the array
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    if (rs2 != 5'd0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
  end

  always_comb begin
    imm       = '0;
    alt       = 1'b0;
    reg_write = 1'b0;
    ctrl      = '0;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alt       = instruction_dec[30];
        rs2_used  = 1'b1;
      end
      OP_IMM: begin
        reg_write = 1'b1;
        ctrl[3]   = 1'b1;
        alt       = (funct3 == 3'b101) && instruction_dec[30];
        imm       = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
      end
      OP_LOAD: begin
        reg_write = 1'b1;
        ctrl[8]   = 1'b1;
        ctrl[3]   = 1'b1;
        imm       = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
      end
      OP_STORE: begin
        ctrl[7]  = 1'b1;
        ctrl[3]  = 1'b1;
        rs2_used = 1'b1;
        imm      = {{20{instruction_dec[31]}}, instruction_dec[31:25], instruction_dec[11:7]};
      end
      OP_BRANCH: begin
        ctrl[6]  = 1'b1;
        rs2_used = 1'b1;
        imm      = {{20{instruction_dec[31]}}, instruction_dec[7], instruction_dec[30:25],
                    instruction_dec[11:8], 1'b0};
      end
      OP_JAL: begin
        reg_write = 1'b1;
        ctrl[5]   = 1'b1;
        rs1_used  = 1'b0;
        imm       = {{12{instruction_dec[31]}}, instruction_dec[19:12], instruction_dec[20],
                     instruction_dec[30:21], 1'b0};
      end
      OP_JALR: begin
        reg_write = 1'b1;
        ctrl[4]   = 1'b1;
        ctrl[3]   = 1'b1;
        imm       = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
      end
      OP_LUI: begin
        reg_write = 1'b1;
        ctrl[2]   = 1'b1;
        rs1_used  = 1'b0;
        imm       = {instruction_dec[31:12], 12'b0};
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        ctrl[1]   = 1'b1;
        rs1_used  = 1'b0;
        imm       = {instruction_dec[31:12], 12'b0};
      end
      default: begin
        // Only the exact halt word is legal among system encodings
        ctrl[0] = !is_halt;
      end
    endcase
    ctrl[9] = reg_write && (rd != 5'd0);
  end

  assign hazard = ctrl_ex[8] && (rd_ex != 5'd0) &&
                  ((rs1_used && rd_ex == rs1) || (rs2_used && rd_ex == rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_data_ex <= '0;
      rs2_data_ex <= '0;
      imm_ex      <= '0;
      rs1_ex      <= '0;
      rs2_ex      <= '0;
      rd_ex       <= '0;
      funct3_ex   <= '0;
      alt_ex      <= 1'b0;
      ctrl_ex     <= '0;
      pc_curr_ex  <= RESET_PC;
      pc_next_ex  <= RESET_PC;
      halt        <= 1'b0;
    end else if (flush || (!stall_mem && hazard)) begin
      rs1_data_ex <= '0;
      rs2_data_ex <= '0;
      imm_ex      <= NOP_IMM;
      rs1_ex      <= NOP_RS1;
      rs2_ex      <= NOP_RS2;
      rd_ex       <= '0;
      funct3_ex   <= NOP_FUNCT3;
      alt_ex      <= 1'b0;
      ctrl_ex     <= '0;
      pc_curr_ex  <= '0;
      pc_next_ex  <= '0;
    end else if (!stall_mem) begin
      rs1_data_ex <= rs1_val;
      rs2_data_ex <= rs2_val;
      imm_ex      <= imm;
      rs1_ex      <= rs1;
      rs2_ex      <= rs2;
      rd_ex       <= rd;
      funct3_ex   <= funct3;
      alt_ex      <= alt;
      ctrl_ex     <= ctrl;
      pc_curr_ex  <= pc_curr_dec;
      pc_next_ex  <= pc_next_dec;
      if (is_halt) halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'h00000100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_dec;
  logic [31:0] pc_curr_dec, pc_next_dec;
  logic        flush, stall_mem, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        hazard, halt;
  logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [2:0]  funct3_ex;
  logic        alt_ex;
  logic [9:0]  ctrl_ex;
  logic [31:0] pc_curr_ex, pc_next_ex;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .instruction_dec(instruction_dec),
    .pc_curr_dec(pc_curr_dec), .pc_next_dec(pc_next_dec),
    .flush(flush), .stall_mem(stall_mem),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard(hazard), .halt(halt),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .funct3_ex(funct3_ex), .alt_ex(alt_ex), .ctrl_ex(ctrl_ex),
    .pc_curr_ex(pc_curr_ex), .pc_next_ex(pc_next_ex)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    instruction_dec = instr;
    pc_curr_dec     = pc;
    pc_next_dec     = pc + 32'd4;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall_mem = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    issue(32'h00000013, 32'h0);
    repeat (2) cycle();
    check_eq("rst_pc_curr", pc_curr_ex, RST_PC);
    check_eq("rst_pc_next", pc_next_ex, RST_PC);
    check_eq("rst_ctrl", {22'b0, ctrl_ex}, 32'h0);
    check_eq("rst_halt", {31'b0, halt}, 32'h0);
    check_eq("rst_hazard", {31'b0, hazard}, 32'h0);

    // writeback x5, then read it back through add x6,x5,x0
    rst_n = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    cycle();
    wb_en = 1'b0;
    issue(32'h00028333, 32'h10);
    #1;
    check_eq("add_before_edge_rd", {27'b0, rd_ex}, 32'd0);
    cycle();
    check_eq("add_rs1_data", rs1_data_ex, 32'hDEADBEEF);
    check_eq("add_ctrl", {22'b0, ctrl_ex}, 32'h200);
    check_eq("add_rd", {27'b0, rd_ex}, 32'd6);
    check_eq("add_pc_curr", pc_curr_ex, 32'h10);
    check_eq("add_pc_next", pc_next_ex, 32'h14);

    // same-cycle bypass: addi x8,x7,-1 while x7 is written
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678;
    issue(32'hFFF38413, 32'h14);
    cycle();
    check_eq("byp_rs1_data", rs1_data_ex, 32'h12345678);
    check_eq("byp_imm", imm_ex, 32'hFFFFFFFF);
    check_eq("byp_ctrl", {22'b0, ctrl_ex}, 32'h208);

    // x0 writes are dropped, including the bypass path: add x9,x0,x0
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    issue(32'h000004B3, 32'h18);
    cycle();
    check_eq("x0_rs1_data", rs1_data_ex, 32'h0);
    wb_en = 1'b0;

    // load-use: lw x3,0(x1) then add x4,x3,x2
    issue(32'h0000A183, 32'h20);
    cycle();
    check_eq("lw_ctrl", {22'b0, ctrl_ex}, 32'h308);
    issue(32'h00218233, 32'h24);
    #1;
    check_eq("lu_hazard", {31'b0, hazard}, 32'h1);
    cycle();
    check_eq("lu_bubble_ctrl", {22'b0, ctrl_ex}, 32'h0);
    check_eq("lu_bubble_rd", {27'b0, rd_ex}, 32'd0);
    check_eq("lu_bubble_pc", pc_curr_ex, 32'h0);
    check_eq("lu_hazard_clear", {31'b0, hazard}, 32'h0);
    cycle();
    check_eq("lu_reissue_ctrl", {22'b0, ctrl_ex}, 32'h200);
    check_eq("lu_reissue_rd", {27'b0, rd_ex}, 32'd4);
    check_eq("lu_reissue_pc", pc_curr_ex, 32'h24);

    // lw x0 followed by add x4,x0,x2: no hazard on x0
    issue(32'h0000A003, 32'h28);
    cycle();
    check_eq("lw0_ctrl", {22'b0, ctrl_ex}, 32'h108);
    issue(32'h00200233, 32'h2C);
    #1;
    check_eq("lw0_hazard", {31'b0, hazard}, 32'h0);
    cycle();
    check_eq("lw0_next_ctrl", {22'b0, ctrl_ex}, 32'h200);

    // stall_mem holds execute for three cycles
    stall_mem = 1'b1;
    issue(32'hABCDE2B7, 32'h40);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_ctrl", {22'b0, ctrl_ex}, 32'h200);
      check_eq("stall_rd", {27'b0, rd_ex}, 32'd4);
      check_eq("stall_pc", pc_curr_ex, 32'h2C);
      check_eq("stall_imm", imm_ex, 32'h0);
    end
    flush = 1'b1;
    cycle();
    check_eq("flush_stall_ctrl", {22'b0, ctrl_ex}, 32'h0);
    check_eq("flush_stall_rd", {27'b0, rd_ex}, 32'd0);
    check_eq("flush_stall_pc", pc_next_ex, 32'h0);
    flush = 1'b0; stall_mem = 1'b0;

    // immediates
    issue(32'hFE000CE3, 32'h50);
    cycle();
    check_eq("beq_imm", imm_ex, 32'hFFFFFFF8);
    check_eq("beq_ctrl", {22'b0, ctrl_ex}, 32'h040);
    issue(32'h001000EF, 32'h54);
    cycle();
    check_eq("jal_imm", imm_ex, 32'h00000800);
    check_eq("jal_ctrl", {22'b0, ctrl_ex}, 32'h220);
    issue(32'hABCDE2B7, 32'h58);
    cycle();
    check_eq("lui_imm", imm_ex, 32'hABCDE000);
    check_eq("lui_ctrl", {22'b0, ctrl_ex}, 32'h204);

    // illegal opcode
    issue(32'h0000007F, 32'h5C);
    cycle();
    check_eq("illegal_ctrl", {22'b0, ctrl_ex}, 32'h001);
    check_eq("illegal_halt", {31'b0, halt}, 32'h0);

    // halt blocked by flush, then taken, then sticky until reset
    issue(32'h00000073, 32'h60);
    flush = 1'b1;
    cycle();
    check_eq("halt_flush", {31'b0, halt}, 32'h0);
    flush = 1'b0;
    cycle();
    check_eq("halt_set", {31'b0, halt}, 32'h1);
    check_eq("halt_ctrl", {22'b0, ctrl_ex}, 32'h0);
    issue(32'h00000013, 32'h64);
    repeat (2) cycle();
    check_eq("halt_sticky", {31'b0, halt}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("halt_rst", {31'b0, halt}, 32'h0);
    check_eq("rst2_pc", pc_curr_ex, RST_PC);
    cycle();
    rst_n = 1'b1;
    issue(32'h00028333, 32'h70);
    cycle();
    check_eq("rst_clears_regs", rs1_data_ex, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage directly downstream of the fetch stage.
- Consumes the fetch-to-decode instruction and the two PC values.
- Reads a 32x32 register file owned by this block, generates immediates and control signals, and registers everything into the decode-to-execute pipeline register.
- Detects load-use hazards and signals fetch to hold the PC.
- Decodes the halt encoding 0x00000073.

Parameters:
- NOP_INSTR, 32'h00000013, encoding treated as bubble (addi x0,x0,0).
- HALT_INSTR, 32'h00000073, encoding that raises halt.
- RESET_PC, 32'h00000000, reset value of the PC fields of the execute register.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- instruction_dec  in  32  instruction from fetch
- pc_curr_dec  in  32  PC of instruction_dec
- pc_next_dec  in  32  PC+4 of instruction_dec
- flush  in  1  branch/interrupt redirect; kill decode contents
- stall_mem  in  1  memory stall; hold execute register
- wb_en  in  1  register-file write enable from writeback
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- hazard  out  1  load-use detected this cycle (combinational)
- halt  out  1  sticky halt
- rs1_data_ex, rs2_data_ex  out  32 each  operand values
- imm_ex  out  32  sign-extended immediate
- rs1_ex, rs2_ex, rd_ex  out  5 each  register indices (for forwarding)
- funct3_ex  out  3  funct3 field
- alt_ex  out  1  instr[30] for SUB/SRA; 0 for I-type non-shift
- ctrl_ex  out  10  {reg_write, mem_read, mem_write, branch, jal, jalr, alu_src_imm, lui, auipc, illegal}
- pc_curr_ex, pc_next_ex  out  32 each  PCs forwarded to execute

Behaviour:
- Reset (async, rst_n=0):
  - All *_ex outputs = 0, with pc_curr_ex = pc_next_ex = RESET_PC.
  - hazard = 0 while in reset; halt = 0.
  - All 31 registers x1..x31 = 0.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write occurs on the rising edge when wb_en=1.
  - Same-cycle read of wb_rd with wb_en=1 returns wb_data (write-through bypass).
- Immediates:
  - I-type: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All are sign-extended from bit 31 of the instruction.
- Opcodes:
  - 0110011 R: reg_write.
  - 0010011 I-ALU: reg_write + alu_src_imm; alt = instr[30] only when funct3 = 101.
  - 0000011 load: reg_write + mem_read + alu_src_imm.
  - 0100011 store: mem_write + alu_src_imm.
  - 1100011 branch: branch.
  - 1101111: jal + reg_write.
  - 1100111: jalr + reg_write + alu_src_imm.
  - 0110111: lui + reg_write.
  - 0010111: auipc + reg_write.
  - 1110011 with instr == HALT_INSTR: no controls set; raises halt.
  - Any other opcode: illegal=1, all other controls 0.
  - reg_write is forced 0 when rd=0.
- Load-use hazard:
  - hazard = ctrl_ex.mem_read & rd_ex≠0 & (rd_ex==rs1 used | rd_ex==rs2 used), evaluated against the current instruction_dec.
  - rs2 counts as used only for R, store and branch.
  - rs1 is not used for lui, auipc or jal.
- Execute-register update priority, per clock edge:
  1. flush: load a bubble (all ctrl 0, rd_ex=0, PCs 0).
  2. stall_mem: hold every *_ex output.
  3. hazard: load a bubble. Fetch holds instruction_dec, so the same instruction re-decodes next cycle, with hazard now 0.
  4. Otherwise: load the decoded instruction.
  - Latency: 1 cycle from instruction_dec to *_ex.
- NOP_INSTR decodes as a normal addi with reg_write = 0 (rd=0); no special path.
- halt:
  - Set on the edge where HALT_INSTR is loaded into the execute register (priority 4 only).
  - Stays 1 until rst_n.
  - A flush or hazard in that cycle prevents it.
- Reset asserted mid-stall or mid-hazard clears everything immediately; no state survives.

Test Plan:
- Reset, then wb_en=1, wb_rd=5, wb_data=0xDEADBEEF; next cycle decode add x6,x5,x0 -> rs1_data_ex=0xDEADBEEF, ctrl_ex.reg_write=1, rd_ex=6, one cycle after instruction_dec.
- Same-cycle bypass: wb writes x7=0x12345678 while instruction_dec=addi x8,x7,-1 -> rs1_data_ex=0x12345678, imm_ex=0xFFFFFFFF.
- Load-use: lw x3,0(x1) then add x4,x3,x2 -> hazard=1 for one cycle, bubble in execute, add issues the following cycle. Repeat with lw x0 -> hazard=0.
- Priority: flush=1 and stall_mem=1 together -> bubble loaded. stall_mem alone for 3 cycles -> all *_ex outputs unchanged.
- Immediates: beq with offset -8 -> imm_ex=0xFFFFFFF8; jal with offset +2048 -> imm_ex=0x00000800; lui 0xABCDE -> imm_ex=0xABCDE000.
- Halt and illegal: instruction_dec=0x00000073 -> halt=1 after one edge, sticky, cleared only by rst_n. Opcode 0x7F -> illegal=1 with other ctrl bits 0. Halt with flush the same cycle -> halt stays 0.
